// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential eight-digit signed BCD to 32-bit two's-complement
// converter using reverse double-dabble (shift right, subtract 3 from every
// nibble >= 8). A start/done handshake frames each conversion. A valid
// conversion takes 32 SHIFT cycles plus one FINISH cycle. Digits above 9 are
// rejected in one cycle with error set and binary forced to zero.

// Protocol checker: the handshake outputs must stay mutually consistent.
module bcd_to_binary_checker #(
    parameter int WIDTH = 32'sd32
) (
    input logic             clk,
    input logic             reset,
    input logic             busy,
    input logic             done,
    input logic             error,
    input logic [WIDTH-1:0] binary
);

    // done is only raised as busy drops, so both are never high together
    a_done_not_busy: assert property (@(posedge clk) disable iff (reset)
        !(done && busy));

    // done is a single-cycle pulse
    a_done_pulse: assert property (@(posedge clk) disable iff (reset)
        done |=> !done);

    // a rejected conversion always reports a zero result
    a_error_zero: assert property (@(posedge clk) disable iff (reset)
        error |-> (binary == '0));

endmodule

module bcd_to_binary #(
    parameter int DIGITS = 32'sd8,
    parameter int WIDTH  = 32'sd32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             neg,
    input  logic [3:0]       first,
    input  logic [3:0]       second,
    input  logic [3:0]       third,
    input  logic [3:0]       fourth,
    input  logic [3:0]       fifth,
    input  logic [3:0]       sixth,
    input  logic [3:0]       seventh,
    input  logic [3:0]       eighth,
    output logic [WIDTH-1:0] binary,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int BCD_W = DIGITS * 32'sd4;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 32'sd1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Reverse double-dabble correction for one digit: after a right shift a
    // nibble >= 8 has absorbed a bit worth 10 in decimal that is worth 16 in
    // binary, so 3 is taken back out.
    function automatic logic [3:0] adjust_nibble(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd8) begin
            res = nib - 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // Apply the per-digit correction across the whole BCD register.
    function automatic logic [BCD_W-1:0] adjust_bcd(input logic [BCD_W-1:0] b);
        return {adjust_nibble(b[31:28]), adjust_nibble(b[27:24]),
                adjust_nibble(b[23:20]), adjust_nibble(b[19:16]),
                adjust_nibble(b[15:12]), adjust_nibble(b[11:8]),
                adjust_nibble(b[7:4]),   adjust_nibble(b[3:0])};
    endfunction

    // True when one digit code lies outside 0..9.
    function automatic logic nibble_invalid(input logic [3:0] nib);
        return (nib > 4'd9);
    endfunction

    // True when any of the eight digits is not a decimal digit.
    function automatic logic bcd_invalid(input logic [BCD_W-1:0] b);
        return nibble_invalid(b[31:28]) | nibble_invalid(b[27:24]) |
               nibble_invalid(b[23:20]) | nibble_invalid(b[19:16]) |
               nibble_invalid(b[15:12]) | nibble_invalid(b[11:8])  |
               nibble_invalid(b[7:4])   | nibble_invalid(b[3:0]);
    endfunction

    state_t            state_r, state_next_s;
    logic [BCD_W-1:0]  bcd_r, bcd_next_s;
    logic [WIDTH-1:0]  acc_r, acc_next_s;
    logic [CNT_W-1:0]  count_r, count_next_s;
    logic              neg_r, neg_next_s;
    logic              invalid_r, invalid_next_s;
    logic [WIDTH-1:0]  binary_r, binary_next_s;
    logic              busy_r, busy_next_s;
    logic              done_r, done_next_s;
    logic              error_r, error_next_s;

    logic [BCD_W-1:0]  digits_s;
    logic [BCD_W-1:0]  shifted_bcd_s;
    logic [WIDTH-1:0]  shifted_acc_s;

    assign digits_s      = {eighth, seventh, sixth, fifth, fourth, third, second, first};
    assign shifted_bcd_s = {1'b0, bcd_r[BCD_W-1:1]};
    assign shifted_acc_s = {bcd_r[0], acc_r[WIDTH-1:1]};

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            bcd_r     <= '0;
            acc_r     <= '0;
            count_r   <= '0;
            neg_r     <= 1'b0;
            invalid_r <= 1'b0;
            binary_r  <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            bcd_r     <= bcd_next_s;
            acc_r     <= acc_next_s;
            count_r   <= count_next_s;
            neg_r     <= neg_next_s;
            invalid_r <= invalid_next_s;
            binary_r  <= binary_next_s;
            busy_r    <= busy_next_s;
            done_r    <= done_next_s;
            error_r   <= error_next_s;
        end
    end

    // Next-state and next-register values; everything holds unless the
    // current state says otherwise, and done defaults low so it pulses.
    always_comb begin
        state_next_s   = state_r;
        bcd_next_s     = bcd_r;
        acc_next_s     = acc_r;
        count_next_s   = count_r;
        neg_next_s     = neg_r;
        invalid_next_s = invalid_r;
        binary_next_s  = binary_r;
        busy_next_s    = busy_r;
        done_next_s    = 1'b0;
        error_next_s   = error_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    bcd_next_s     = digits_s;
                    acc_next_s     = '0;
                    neg_next_s     = neg;
                    count_next_s   = '0;
                    invalid_next_s = bcd_invalid(digits_s);
                    busy_next_s    = 1'b1;
                    if (bcd_invalid(digits_s)) begin
                        state_next_s = FINISH;
                    end else begin
                        state_next_s = SHIFT;
                    end
                end else begin
                    busy_next_s  = 1'b0;
                    state_next_s = IDLE;
                end
            end

            SHIFT: begin
                bcd_next_s   = adjust_bcd(shifted_bcd_s);
                acc_next_s   = shifted_acc_s;
                count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (count_r == LAST_COUNT) begin
                    state_next_s = FINISH;
                end else begin
                    state_next_s = SHIFT;
                end
            end

            FINISH: begin
                if (invalid_r) begin
                    binary_next_s = '0;
                    error_next_s  = 1'b1;
                end else begin
                    error_next_s = 1'b0;
                    if (neg_r) begin
                        binary_next_s = ~acc_r + {{(WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        binary_next_s = acc_r;
                    end
                end
                done_next_s  = 1'b1;
                busy_next_s  = 1'b0;
                state_next_s = IDLE;
            end

            default: begin
                busy_next_s  = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    assign binary = binary_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign error  = error_r;

    bcd_to_binary_checker #(
        .WIDTH (WIDTH)
    ) u_checker (
        .clk    (clk),
        .reset  (reset),
        .busy   (busy_r),
        .done   (done_r),
        .error  (error_r),
        .binary (binary_r)
    );

endmodule
